// File: rtl/i2c_pkg.sv
// Shared I2C constants used by the RX FIFO, register block and master logic.
package i2c_pkg;
  localparam int BYTE_W           = 8;
  localparam int RX_FIFO_DEPTH    = 8;
  localparam int RX_FIFO_AF_LEVEL = 7;
endpackage

// File: rtl/i2c_rx_fifo_mem.sv
// RX FIFO storage: one synchronous write port, one asynchronous read port.
module i2c_rx_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/i2c_rx_fifo.sv
// I2C receive-byte FIFO, first-word-fall-through toward the APB side,
// with registered occupancy flags and overflow/underflow pulses.
module i2c_rx_fifo
  import i2c_pkg::*;
#(
  parameter int DATA_W   = BYTE_W,
  parameter int DEPTH    = RX_FIFO_DEPTH,
  parameter int AF_LEVEL = RX_FIFO_AF_LEVEL
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [CW-1:0]     next_count;
  logic [DATA_W-1:0] head;
  logic              do_wr;
  logic              do_rd;
  logic              mem_we;

  // A full FIFO still takes a write when the head is popped the same cycle.
  assign do_wr      = wr_en & (~full | rd_en);
  assign do_rd      = rd_en & ~empty;
  assign mem_we     = do_wr & ~flush & ~n_rst;
  assign next_count = count + CW'(do_wr) - CW'(do_rd);

  i2c_rx_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

  assign rd_data = empty ? '0 : head;

  always_ff @(posedge clk) begin
    if (n_rst || flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count       <= next_count;
      empty       <= (next_count == '0);
      full        <= (next_count == CW'(DEPTH));
      almost_full <= (next_count >= CW'(AF_LEVEL));
      overflow    <= wr_en & full & ~rd_en;
      underflow   <= rd_en & empty;
    end
  end

endmodule

// File: tb/tb_i2c_rx_fifo.sv
// Self-checking bench for i2c_rx_fifo: directed vector table, corner
// sequences and random traffic against a queue reference model.
module tb_i2c_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AFL   = 7;

  logic          clk = 1'b0;
  logic          n_rst, flush, wr_en, rd_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          empty, full, almost_full, overflow, underflow;
  logic [3:0]    count;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic       m_ov, m_un;

  always #5 clk = ~clk;

  i2c_rx_fifo dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .flush       (flush),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  typedef struct {
    logic       rst;
    logic       fl;
    logic       wr;
    logic       rd;
    logic [7:0] d;
    int         cnt;
    logic [7:0] rdd;
    logic       ov;
    logic       un;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: FIFO as a queue, rules applied to pre-edge occupancy.
  task automatic model(input logic rst, input logic fl,
                       input logic wr, input logic rd, input logic [7:0] d);
    bit was_full, was_empty;
    if (rst || fl) begin
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      m_ov = wr && was_full && !rd;
      m_un = rd && was_empty;
      if (rd && !was_empty) void'(q.pop_front());
      if (wr && (!was_full || rd)) q.push_back(d);
    end
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("count", int'(count), n);
    chk("empty", int'(empty), int'(n == 0));
    chk("full", int'(full), int'(n == DEPTH));
    chk("almost_full", int'(almost_full), int'(n >= AFL));
    chk("rd_data", int'(rd_data), (n == 0) ? 0 : int'(q[0]));
    chk("overflow", int'(overflow), int'(m_ov));
    chk("underflow", int'(underflow), int'(m_un));
  endtask

  task automatic step(input logic rst, input logic fl, input logic wr,
                      input logic rd, input logic [7:0] d);
    n_rst   = rst;
    flush   = fl;
    wr_en   = wr;
    rd_en   = rd;
    wr_data = d;
    @(posedge clk);
    model(rst, fl, wr, rd, d);
    #1;
    check_model();
    n_rst = 1'b0;
    flush = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    step(1'b0, 1'b0, 1'b1, 1'b0, d);
  endtask

  task automatic pop();
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    n_rst   = 1'b1;
    flush   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    m_ov    = 1'b0;
    m_un    = 1'b0;

    //        rst   fl    wr    rd    d      cnt rdd    ov    un
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 8'h00, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1, 8'hA5, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 2, 8'hA5, 1'b0, 1'b0};
    vt[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1, 8'h3C, 1'b0, 1'b0};
    vt[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h00, 1'b0, 1'b0};
    vt[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h00, 1'b0, 1'b1};
    vt[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1, 8'h11, 1'b0, 1'b1};
    vt[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h00, 1'b0, 1'b0};
    vt[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h00, 1'b0, 1'b1};

    for (int i = 0; i < 9; i++) begin
      step(vt[i].rst, vt[i].fl, vt[i].wr, vt[i].rd, vt[i].d);
      chk($sformatf("vec%0d.count", i), int'(count), vt[i].cnt);
      chk($sformatf("vec%0d.rd_data", i), int'(rd_data), int'(vt[i].rdd));
      chk($sformatf("vec%0d.overflow", i), int'(overflow), int'(vt[i].ov));
      chk($sformatf("vec%0d.underflow", i), int'(underflow), int'(vt[i].un));
    end

    // Fill, overflow, drain in order.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push(8'(i));
      chk("fill.af", int'(almost_full), int'(i + 1 >= 7));
      chk("fill.full", int'(full), int'(i == 7));
    end
    push(8'hFF);
    chk("ovf.pulse", int'(overflow), 1);
    chk("ovf.count", int'(count), 8);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("ovf.clear", int'(overflow), 0);
    for (int i = 0; i < 8; i++) begin
      chk("drain.data", int'(rd_data), i);
      pop();
    end
    chk("drain.empty", int'(empty), 1);

    // Simultaneous push/pop while full, across pointer wrap.
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(i));
    for (int i = 0; i < 3; i++) begin
      chk("wrrd.head", int'(rd_data), i);
      step(1'b0, 1'b0, 1'b1, 1'b1, 8'h99);
      chk("wrrd.no_ovf", int'(overflow), 0);
      chk("wrrd.count", int'(count), 8);
    end
    for (int i = 0; i < 8; i++) begin
      chk("wrrd.drain", int'(rd_data), (i < 5) ? i + 3 : 'h99);
      pop();
    end
    chk("wrrd.empty", int'(empty), 1);

    // Flush with concurrent write.
    do_reset();
    for (int i = 0; i < 5; i++) push(8'(i + 'h20));
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h77);
    chk("flush.count", int'(count), 0);
    chk("flush.empty", int'(empty), 1);
    chk("flush.ovf", int'(overflow), 0);
    push(8'h42);
    chk("flush.next", int'(rd_data), 'h42);

    // Reset beats flush and write.
    for (int i = 0; i < 3; i++) push(8'(i + 'h50));
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h66);
    chk("rst.count", int'(count), 0);
    chk("rst.empty", int'(empty), 1);
    chk("rst.full", int'(full), 0);
    chk("rst.rd_data", int'(rd_data), 0);

    // Random traffic with varying fill pressure.
    for (int blk = 0; blk < 20; blk++) begin
      int wp;
      wp = (blk % 3 == 0) ? 85 : ((blk % 3 == 1) ? 50 : 20);
      for (int c = 0; c < 100; c++) begin
        logic r_rst, r_fl, r_wr, r_rd;
        r_rst = ($urandom_range(0, 199) == 0);
        r_fl  = ($urandom_range(0, 59) == 0);
        r_wr  = ($urandom_range(0, 99) < wp);
        r_rd  = ($urandom_range(0, 99) < 100 - wp);
        step(r_rst, r_fl, r_wr, r_rd, 8'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
